// File: rtl/riscv_wb_monitor.sv
// Writeback trace monitor: shadows the architectural register file, queues retired writes
// as trace records, and can serialise the whole shadow file over the same output stream.
module riscv_wb_monitor #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_e,
   input  logic [4:0]  wb_a,
   input  logic [31:0] wb_d,
   input  logic        dump_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_kind,
   output logic [4:0]  out_addr,
   output logic [31:0] out_data,
   input  logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        overflow,
   output logic [31:0] wb_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StStream, StDumpWait, StDump} state_e;

   state_e      state_q, state_d;
   logic [4:0]  idx_q;
   logic        busy_q;
   logic        out_valid_q, out_kind_q;
   logic [4:0]  out_addr_q;
   logic [31:0] out_data_q;
   logic        overflow_q;
   logic [31:0] wb_count_q;
   logic [31:0] shadow_q [32];
   logic [4:0]  fifo_addr_q [FIFO_DEPTH];
   logic [31:0] fifo_data_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;

   logic wb_acc, fifo_empty, fifo_full, out_load, pop, push;

   assign wb_acc     = wb_e && (wb_a != 5'd0);
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign out_load   = !out_valid_q || out_ready;
   assign pop        = (state_q != StDump) && out_load && !fifo_empty;
   // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
   assign push       = wb_acc && (!fifo_full || pop);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StStream:   if (dump_req) state_d = StDumpWait;
         StDumpWait: if (fifo_empty) state_d = StDump;
         StDump:     if (out_load && (idx_q == 5'd31)) state_d = StStream;
         default:    state_d = StStream;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StStream;
         busy_q      <= 1'b0;
         idx_q       <= 5'd0;
         out_valid_q <= 1'b0;
         out_kind_q  <= 1'b0;
         out_addr_q  <= 5'd0;
         out_data_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StStream);
         if (state_q == StDumpWait) idx_q <= 5'd0;
         if (out_load) begin
            if (state_q == StDump) begin
               // Registered shadow read yields the value from before any same-edge write.
               out_valid_q <= 1'b1;
               out_kind_q  <= 1'b1;
               out_addr_q  <= idx_q;
               out_data_q  <= shadow_q[idx_q];
               idx_q       <= idx_q + 5'd1;
            end else if (!fifo_empty) begin
               out_valid_q <= 1'b1;
               out_kind_q  <= 1'b0;
               out_addr_q  <= fifo_addr_q[rd_ptr_q[AW-1:0]];
               out_data_q  <= fifo_data_q[rd_ptr_q[AW-1:0]];
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[AW-1:0]] <= wb_a;
         fifo_data_q[wr_ptr_q[AW-1:0]] <= wb_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) shadow_q[i] <= 32'd0;
         wb_count_q <= 32'd0;
         overflow_q <= 1'b0;
      end else if (wb_acc) begin
         shadow_q[wb_a] <= wb_d;
         wb_count_q     <= wb_count_q + 32'd1;
         if (!push) overflow_q <= 1'b1;
      end
   end

   assign rd_data   = (rd_addr == 5'd0) ? 32'd0 : shadow_q[rd_addr];
   assign out_valid = out_valid_q;
   assign out_kind  = out_kind_q;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;
   assign wb_count  = wb_count_q;

endmodule
